// File: rtl/last_stage_arbiter.sv
// last_stage_arbiter
//   Two-client round-robin front end and sequencer for the 4-bit last-stage
//   delay unit. One transaction is in flight at a time: grant, drive the unit,
//   wait LAT_BASE+mode cycles, capture y, then pulse done to the owner.
//
// Ports
//   clk            rising-edge clock
//   clear          asynchronous active-low reset
//   req0/req1      client requests, held until the matching grant
//   data0/data1    client operands (4b)
//   mode0/mode1    client delay modes (2b): bit1 -> sel_1, bit0 -> sel
//   gnt0/gnt1      one-cycle grant pulses (ISSUE cycle)
//   done0/done1    one-cycle completion pulses, result valid alongside
//   result         captured y of the last completed transaction
//   busy           high whenever the sequencer is not IDLE
//   a/sel/sel_1    delay-unit inputs, non-zero only in ISSUE and WAIT
//   y              delay-unit output
//
// Every output is a flop, so nothing on req/data/mode/y reaches an output
// combinationally. LAT_BASE must lie in 1..4 so that LAT_BASE+mode fits cnt.
module last_stage_arbiter #(
  parameter int LAT_BASE = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [1:0] mode0,
  input  logic [1:0] mode1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       busy,
  output logic [3:0] a,
  output logic       sel,
  output logic       sel_1,
  input  logic [3:0] y
);

  localparam int         NCLI = 2;
  localparam logic [2:0] LB   = 3'(LAT_BASE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] mode;
  } creq_t;

  // Clients folded into packed vectors so arbitration is index-based.
  logic  [NCLI-1:0] req;
  creq_t [NCLI-1:0] creq;

  assign req     = {req1, req0};
  assign creq[0] = {data0, mode0};
  assign creq[1] = {data1, mode1};

  state_t           state, nxt;
  logic             ptr;      // priority client when both request
  logic             owner;    // client that owns the in-flight transaction
  logic [2:0]       cnt;      // remaining WAIT cycles
  logic             any_req;
  logic             win;
  logic             take;     // IDLE -> ISSUE this cycle
  logic             last;     // final WAIT cycle, y is captured on this edge

  // Output flops and their next values.
  logic [NCLI-1:0]  gnt_q, gnt_d;
  logic [NCLI-1:0]  done_q, done_d;
  logic [3:0]       a_d, result_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_d;

  // Arbitration: a lone requester wins; on a tie the ptr client wins.
  always_comb begin
    any_req = |req;
    win     = (&req) ? ptr : req[1];
    take    = (state == IDLE) && any_req;
    last    = (state == WAIT) && (cnt == 3'd1);
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (any_req) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (cnt == 3'd1) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Next values for the registered outputs, keyed off the state being entered
  // so each output is valid in the same cycle as its state.
  always_comb begin
    a_d      = '0;
    mode_d   = '0;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = (nxt != IDLE);
    result_d = last ? y : result;
    unique case (nxt)
      ISSUE: begin
        // ISSUE is only reachable from IDLE: load the winner's operands.
        a_d    = creq[win].data;
        mode_d = creq[win].mode;
      end
      WAIT: begin
        a_d    = a;
        mode_d = mode_q;
      end
      DONE:    done_d[owner] = 1'b1;
      default: ;
    endcase
    if (take) gnt_d[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      gnt_q  <= '0;
      done_q <= '0;
      busy   <= 1'b0;
      a      <= '0;
      mode_q <= '0;
      result <= '0;
    end else begin
      gnt_q  <= gnt_d;
      done_q <= done_d;
      busy   <= busy_d;
      a      <= a_d;
      mode_q <= mode_d;
      result <= result_d;
    end
  end

  // ---------------------------------------------------------------- datapath
  // cnt is loaded with N at grant time and held through ISSUE, so WAIT lasts
  // exactly N cycles.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      if (take) begin
        owner <= win;
        ptr   <= ~win;
        cnt   <= LB + {1'b0, creq[win].mode};
      end else if (state == WAIT) begin
        cnt   <= cnt - 3'd1;
      end
    end
  end

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign sel   = mode_q[0];
  assign sel_1 = mode_q[1];

endmodule

// File: doc/last_stage_arbiter.md
# last_stage_arbiter

Sequencer and two-requester arbiter for the 4-bit last-stage delay unit (`delay`). Accepts requests from two upstream clients, grants the shared unit round-robin, and drives its `a`, `sel`, `sel_1` inputs. It waits out the selected delay, captures `y`, and returns the result to the owning client with a done pulse. Only one transaction is in flight at a time.

## Interface
Parameters
- `LAT_BASE`, default 1: fixed latency of the delay unit in cycles, added to the mode count. Legal range is 1..4.

Ports
- `clk`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  client request. Held high until the matching grant is seen.
- `data0`, `data1`  in  4  client operand, valid while the matching `req` is high.
- `mode0`, `mode1`  in  2  client delay mode. Bit 1 maps to `sel_1`, bit 0 to `sel`.
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse.
- `done0`, `done1`  out  1  one-cycle completion pulse. `result` is valid in the same cycle.
- `result`  out  4  captured `y` of the last completed transaction.
- `busy`  out  1  high when not IDLE.
- `a`  out  4  operand to the delay unit.
- `sel`, `sel_1`  out  1  mode selects to the delay unit.
- `y`  in  1..4 → 4  output of the delay unit.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when `req0` or `req1` is sampled high.
  - ISSUE → WAIT.
  - WAIT → DONE when `cnt` == 1.
  - DONE → IDLE.
- Arbitration happens in IDLE only.
  - Pointer `ptr` (0 or 1) names the priority client. Its reset value is 0.
  - If only one client requests, that client wins.
  - If both request, the `ptr` client wins.
  - After a grant, `ptr` moves to the other client.
- On the IDLE→ISSUE edge, the winner's `data` and `mode` are captured internally. The owner ID is latched.
- Wait count: `cnt` is loaded with N = `LAT_BASE` + mode (range 1..7). It is 3-bit, with no overflow for legal `LAT_BASE`.
- During ISSUE and WAIT, `a`, `sel` and `sel_1` carry the captured values and are stable. In IDLE and DONE they are 0.
- In WAIT, `cnt` decrements each cycle. On the edge where `cnt` == 1, `result` <= `y` and the state goes to DONE.
- In DONE, `done[owner]` is 1. `result` holds its value until the next capture.
- `req` inputs are ignored outside IDLE. A `req` still high in IDLE after DONE counts as a new request.
- Reset (`clear` = 0, at any time, including mid-transaction):
  - State goes to IDLE and `ptr` to 0.
  - `cnt`, `a`, `sel`, `sel_1`, `result`, `gnt*`, `done*` and `busy` all go to 0.
  - An in-flight transaction is discarded with no `done`.

## Timing
- Cycle t (IDLE): req sampled high.
- Cycle t+1 (ISSUE): `gnt` = 1 and `busy` = 1. The delay-unit inputs become valid.
- Cycles t+2 .. t+1+N (WAIT): `y` is sampled at the end of cycle t+1+N.
- Cycle t+2+N (DONE): `done` = 1 and `result` is valid.
- Cycle t+3+N: IDLE. A pending request is arbitrated in that same cycle.
- Request-to-done latency is N+2 cycles. Back-to-back throughput is one transaction per N+3 cycles.
- All outputs are registered. No combinational path exists from `req`/`data`/`mode`/`y` to any output.
- If `clear` is released in the same cycle as a `req`, the request is sampled on the first rising edge after release.

## Test plan
Bench model for the delay unit: `y` = `a` delayed by `LAT_BASE` + {`sel_1`,`sel`} cycles. All scenarios use `LAT_BASE` = 1.

- **Single request.** Drive `req0`, `data0` = 4, `mode0` = 0.
  - `gnt0` 1 cycle later.
  - `done0` and `result` = 4 3 cycles after the request.
  - `gnt1` and `done1` never assert.
- **Max mode.** Drive `req1`, `data1` = 9, `mode1` = 3.
  - `sel` = `sel_1` = 1 throughout ISSUE and WAIT.
  - `done1` with `result` = 9 exactly 6 cycles after the request.
- **Simultaneous requests.** Hold `req0`/`req1` high with `data` 1/2, modes 1/2.
  - Grant order is 0 then 1 (`ptr` = 0 after reset).
  - `result` = 1 then 2.
  - The second grant falls in the cycle after `done0` + 1.
  - Requests then alternate fairly: no client is granted twice in a row while the other is waiting.
- **Requests outside IDLE.** Assert `req0` only during WAIT.
  - It is not granted until IDLE.
  - `a` stays stable through WAIT.
- **Reset mid-operation.** Pull `clear` low in WAIT.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No `done` is produced.
  - After release, the first request from either client gets a grant exactly 1 cycle later.
